// File: rtl/connector_pkg.sv
// rtl/connector_pkg.sv - shared widths and beat type for the trace ingress path
//
// Purpose: field widths of the CVA6 trace connector and te_beat_t, the unit
// stored by te_beat_fifo (one full input beat: all lanes plus shared fields).
package connector_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 32;
  localparam int ITYPE_LEN   = 3;
  localparam int PRIV_LEN    = 2;

  // Lanes per beat; te_beat_t is sized by this value.
  localparam int TE_N        = 2;

  typedef struct packed {
    logic [TE_N-1:0]                  valid;
    logic [TE_N-1:0][IRETIRE_LEN-1:0] iretire;
    logic [TE_N-1:0]                  ilastsize;
    logic [TE_N-1:0][ITYPE_LEN-1:0]   itype;
    logic [TE_N-1:0][XLEN-1:0]        iaddr;
    logic [XLEN-1:0]                  cause;
    logic [XLEN-1:0]                  tval;
    logic [PRIV_LEN-1:0]              priv;
  } te_beat_t;

endpackage

// File: rtl/te_beat_fifo.sv
// rtl/te_beat_fifo.sv - DEPTH-entry synchronous FIFO of trace beats
//
// Purpose: stores whole beats; head entry is read combinationally.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, data_i     write request and beat; taken when not full or when
//                      a pop happens in the same cycle
//   pop_i              remove head (ignored when empty)
//   head_o             current head beat (undefined content when empty)
//   empty_o, count_o   occupancy status; full is count_o == DEPTH
module te_beat_fifo
  import connector_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  te_beat_t      data_i,
  input  logic          pop_i,
  output te_beat_t      head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  te_beat_t      r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop_i && !w_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_do_push) r_mem[r_wptr] <= data_i;
  end

  assign head_o  = r_mem[r_rptr];
  assign empty_o = w_empty;
  assign count_o = r_count;

endmodule

// File: rtl/te_block_serializer.sv
// rtl/te_block_serializer.sv - buffers multi-lane trace beats, emits one block per cycle
//
// Purpose: receiving end of the CVA6 trace ingress. Whole beats go into a
// FIFO; the head beat is replayed lane by lane (ascending, invalid lanes
// skipped) over a valid/ready port. Beats arriving while full are dropped
// and counted.
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   valid_i .. iaddr_i               input beat (per-lane fields, shared
//                                    cause/tval/priv), no backpressure
//   ready_i                          downstream accepts the block
//   valid_o, lane_o, *_o             presented block, zero when empty
//   empty_o                          FIFO holds no beat
//   overflow_o, drop_cnt_o           sticky drop flag, saturating count
module te_block_serializer
  import connector_pkg::*;
#(
  parameter int N       = TE_N,
  parameter int DEPTH   = 4,
  parameter int CNT_LEN = 16,
  localparam int LW     = (N > 1) ? $clog2(N) : 1,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N-1:0]                valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i,
  input  logic [N-1:0]                ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0] itype_i,
  input  logic [XLEN-1:0]             cause_i,
  input  logic [XLEN-1:0]             tval_i,
  input  logic [PRIV_LEN-1:0]         priv_i,
  input  logic [N-1:0][XLEN-1:0]      iaddr_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [LW-1:0]               lane_o,
  output logic [IRETIRE_LEN-1:0]      iretire_o,
  output logic                        ilastsize_o,
  output logic [ITYPE_LEN-1:0]        itype_o,
  output logic [XLEN-1:0]             iaddr_o,
  output logic [XLEN-1:0]             cause_o,
  output logic [XLEN-1:0]             tval_o,
  output logic [PRIV_LEN-1:0]         priv_o,
  output logic                        empty_o,
  output logic                        overflow_o,
  output logic [CNT_LEN-1:0]          drop_cnt_o
);

  // te_beat_t is sized by the package lane count.
  if (N != TE_N) begin : g_lane_count_check
    $error("te_block_serializer: N must equal connector_pkg::TE_N");
  end

  te_beat_t      w_beat;
  te_beat_t      w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW-1:0] w_count;

  logic [N-1:0]  r_served;
  logic [N-1:0]  w_pending;
  logic [N-1:0]  w_sel_onehot;
  logic [LW-1:0] w_sel;
  logic          w_valid;
  logic          w_fire;
  logic          w_last;
  logic          w_drop;

  logic               r_overflow;
  logic [CNT_LEN-1:0] r_drop_cnt;

  always_comb begin
    w_beat           = '0;
    w_beat.valid     = valid_i;
    w_beat.iretire   = iretire_i;
    w_beat.ilastsize = ilastsize_i;
    w_beat.itype     = itype_i;
    w_beat.iaddr     = iaddr_i;
    w_beat.cause     = cause_i;
    w_beat.tval      = tval_i;
    w_beat.priv      = priv_i;
  end

  // Beats with no valid lane carry nothing worth replaying.
  assign w_push = |valid_i;

  te_beat_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_beat),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Lanes of the head beat still waiting to be emitted.
  assign w_pending = w_head.valid & ~r_served;

  // Lowest pending lane wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_pending[i]) w_sel = LW'(i);
    end
  end

  assign w_sel_onehot = N'(1) << w_sel;
  assign w_valid      = !w_empty;
  assign w_fire       = w_valid && ready_i;
  assign w_last       = ((w_pending & ~w_sel_onehot) == '0);
  assign w_pop        = w_fire && w_last;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_served <= '0;
    end else if (w_pop) begin
      r_served <= '0;
    end else if (w_fire) begin
      r_served <= r_served | w_sel_onehot;
    end
  end

  // Same acceptance rule as the FIFO: full without a concurrent pop drops.
  assign w_drop = w_push && (w_count == CW'(DEPTH)) && !w_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_LEN'(1);
    end
  end

  always_comb begin
    valid_o     = 1'b0;
    lane_o      = '0;
    iretire_o   = '0;
    ilastsize_o = 1'b0;
    itype_o     = '0;
    iaddr_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    if (w_valid) begin
      valid_o     = 1'b1;
      lane_o      = w_sel;
      iretire_o   = w_head.iretire[w_sel];
      ilastsize_o = w_head.ilastsize[w_sel];
      itype_o     = w_head.itype[w_sel];
      iaddr_o     = w_head.iaddr[w_sel];
      cause_o     = w_head.cause;
      tval_o      = w_head.tval;
      priv_o      = w_head.priv;
    end
  end

  assign empty_o    = w_empty;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule
